// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM receive demultiplexer.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Slot index width; a one-slot frame still needs a 1-bit counter.
    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Expected-slot counter: load-to-1 on a sync beat, increment with wrap otherwise.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int NCH = 2,
    localparam int SLOT_W = slot_w(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic              inc,
    output logic [SLOT_W-1:0] slot,
    output logic              is_last
);

    // After a sync beat the next expected slot is 1, which wraps to 0 for NCH=1.
    localparam logic [SLOT_W-1:0] LOAD_VAL = SLOT_W'((NCH > 1) ? 1 : 0);
    localparam logic [SLOT_W-1:0] LAST     = SLOT_W'(NCH - 1);

    assign is_last = (slot == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (en) begin
            if (load)
                slot <= LOAD_VAL;
            else if (inc)
                slot <= is_last ? '0 : slot + SLOT_W'(1);
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Receive side of the TDM link: frame alignment, per-slot capture and frame snapshot.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 sync,
    output logic [NCH*WIDTH-1:0] ch_data,
    output logic [NCH-1:0]       ch_valid,
    output logic [NCH*WIDTH-1:0] frame_data,
    output logic                 frame_valid,
    output logic                 locked,
    output logic                 sync_err
);

    localparam int SLOT_W = slot_w(NCH);
    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NCH - 1);

    state_t               state;
    logic [SLOT_W-1:0]    slot;
    logic [SLOT_W-1:0]    cap_slot;
    logic                 is_last;
    logic                 capture;
    logic                 err;
    logic                 last_cap;
    logic [NCH*WIDTH-1:0] merged;

    tdm_slot_counter #(.NCH(NCH)) u_slot (
        .clk     (clk),
        .rst     (rst),
        .en      (din_valid),
        .load    (capture && sync),
        .inc     (capture && !sync),
        .slot    (slot),
        .is_last (is_last)
    );

    // A sync beat always lands in slot 0, whether it was expected or is a realign.
    always_comb begin
        capture  = 1'b0;
        err      = 1'b0;
        cap_slot = sync ? '0 : slot;
        if (din_valid) begin
            case (state)
                HUNT: capture = sync;
                LOCK: begin
                    capture = sync || (slot != '0);
                    err     = sync ? (slot != '0) : (slot == '0);
                end
                default: capture = 1'b0;
            endcase
        end
        last_cap = capture && (cap_slot == LAST);
        merged   = ch_data;
        for (int k = 0; k < NCH; k++)
            if (cap_slot == SLOT_W'(k))
                merged[k*WIDTH +: WIDTH] = din;
    end

    assign locked = (state == LOCK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            ch_data     <= '0;
            ch_valid    <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++)
                ch_valid[k] <= capture && (cap_slot == SLOT_W'(k));
            if (capture)
                ch_data <= merged;
            frame_valid <= last_cap;
            if (last_cap)
                frame_data <= merged;
            sync_err <= err;
            // Slot 0 without sync means alignment is lost; drop the beat and re-hunt.
            if (din_valid) begin
                if (state == HUNT && sync)
                    state <= LOCK;
                else if (state == LOCK && !sync && slot == '0)
                    state <= HUNT;
            end
        end
    end

endmodule
